spmv_row_mac: RTL and testbench

SPMV_ROW_MAC -- requirements
Module: spmv_row_mac

---
 rtl/spmv_row_mac_pkg.sv | 18 +
 rtl/mac_adder_tree8.sv | 38 +++
 rtl/spmv_row_mac.sv | 176 +++++++++++++++++
 tb/tb_spmv_row_mac.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/spmv_row_mac_pkg.sv
// Shared defaults and FSM encoding for the sparse matrix-vector row MAC.
// Q16.16 operands, 48-bit wrapping accumulator, one row in flight.
package spmv_row_mac_pkg;

   localparam int ELEMENT_WIDTH_DEF = 32;
   localparam int NO_OF_UNITS_DEF   = 8;
   localparam int FRAC_BITS_DEF     = 16;
   localparam int ACC_WIDTH_DEF     = 48;
   localparam int RESULT_WIDTH      = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/mac_adder_tree8.sv
// Eight-input modular adder tree, one registered sum (1 cycle latency).
// No backpressure: the sum register loads whenever en_i is high.
module mac_adder_tree8 #(
   parameter int W = 48
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en_i,
   input  logic [8*W-1:0] op_i,
   output logic [W-1:0]   sum_o
);

   logic [W-1:0] lvl1_w [4];
   logic [W-1:0] lvl2_w [2];
   logic [W-1:0] sum_d;
   logic [W-1:0] sum_q;

   // Two's complement addition wraps identically for signed operands.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lvl1_w[i] = op_i[(2*i)*W +: W] + op_i[(2*i+1)*W +: W];
      end
      lvl2_w[0] = lvl1_w[0] + lvl1_w[1];
      lvl2_w[1] = lvl1_w[2] + lvl1_w[3];
      sum_d     = lvl2_w[0] + lvl2_w[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (en_i) begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/spmv_row_mac.sv
// Row dot product of gathered vector x matrix values; result_valid 4 cycles after last beat.
// in_ready drops from the last beat until the result handshake; beats arriving then set drop_err.
module spmv_row_mac
   import spmv_row_mac_pkg::*;
#(
   parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
   parameter int NO_OF_UNITS   = NO_OF_UNITS_DEF,
   parameter int FRAC_BITS     = FRAC_BITS_DEF,
   parameter int ACC_WIDTH     = ACC_WIDTH_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] vec_row,
   input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] val_row,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [31:0]                          no_of_multiples,
   output logic [RESULT_WIDTH-1:0]              result,
   output logic                                 result_valid,
   input  logic                                 result_ready,
   output logic                                 overflow,
   output logic                                 drop_err
);

   localparam int EW = ELEMENT_WIDTH;
   localparam int AW = ACC_WIDTH;

   state_e                       state_q, state_d;
   logic [31:0]                  cnt_q, cnt_d;
   logic [31:0]                  total_q, total_d;
   logic                         last_beat;
   logic                         load_res;
   logic                         accept;

   logic [NO_OF_UNITS*AW-1:0]    prod_d, prod_q;
   logic                         s1_vld_q, s1_last_q;
   logic                         s2_vld_q, s2_last_q;
   logic                         s3_last_q, s4_last_q;
   logic [AW-1:0]                tree_sum;
   logic [AW-1:0]                acc_q;
   logic [RESULT_WIDTH-1:0]      sat_d, sat_q, result_q;
   logic                         sat_ovf_d, sat_ovf_q, overflow_q, drop_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         total_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      total_d   = total_q;
      in_ready  = 1'b0;
      last_beat = 1'b0;
      load_res  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               total_d = (no_of_multiples == 32'd0) ? 32'd1 : no_of_multiples;
               cnt_d   = 32'd1;
               if (total_d == 32'd1) begin
                  last_beat = 1'b1;
                  state_d   = DRAIN;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cnt_d = cnt_q + 32'd1;
               if (cnt_d == total_q) begin
                  last_beat = 1'b1;
                  state_d   = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (s4_last_q) begin
               load_res = 1'b1;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   // Floor-shifted Q16.16 products, kept modulo 2^AW like the accumulator.
   always_comb begin
      logic signed [2*EW-1:0] mul_w;
      logic signed [2*EW-1:0] shf_w;
      prod_d = '0;
      mul_w  = '0;
      shf_w  = '0;
      for (int k = 0; k < NO_OF_UNITS; k++) begin
         mul_w = $signed(vec_row[k*EW +: EW]) * $signed(val_row[k*EW +: EW]);
         shf_w = mul_w >>> FRAC_BITS;
         prod_d[k*AW +: AW] = shf_w[AW-1:0];
      end
   end

   mac_adder_tree8 #(.W(AW)) u_tree (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (s1_vld_q),
      .op_i  (prod_q),
      .sum_o (tree_sum)
   );

   // Saturate when the bits above the result sign bit are not a pure sign extension.
   always_comb begin
      logic [AW-RESULT_WIDTH:0] hi_w;
      hi_w      = acc_q[AW-1:RESULT_WIDTH-1];
      sat_ovf_d = !((&hi_w) || !(|hi_w));
      if (!sat_ovf_d)       sat_d = acc_q[RESULT_WIDTH-1:0];
      else if (acc_q[AW-1]) sat_d = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
      else                  sat_d = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q     <= '0;
         s1_vld_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_last_q  <= 1'b0;
         s3_last_q  <= 1'b0;
         s4_last_q  <= 1'b0;
         acc_q      <= '0;
         sat_q      <= '0;
         sat_ovf_q  <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         drop_err_q <= 1'b0;
      end else begin
         if (accept) prod_q <= prod_d;
         s1_vld_q  <= accept;
         s1_last_q <= last_beat;
         s2_vld_q  <= s1_vld_q;
         s2_last_q <= s1_vld_q && s1_last_q;
         if (state_q == IDLE)  acc_q <= '0;
         else if (s2_vld_q)    acc_q <= acc_q + tree_sum;
         s3_last_q <= s2_vld_q && s2_last_q;
         s4_last_q <= s3_last_q;
         if (s3_last_q) begin
            sat_q     <= sat_d;
            sat_ovf_q <= sat_ovf_d;
         end
         if (load_res) begin
            result_q   <= sat_q;
            overflow_q <= sat_ovf_q;
         end
         if (in_valid && !in_ready) drop_err_q <= 1'b1;
      end
   end

   assign result       = result_q;
   assign overflow     = overflow_q;
   assign drop_err     = drop_err_q;
   assign result_valid = (state_q == HOLD);

endmodule

// File: tb/tb_spmv_row_mac.sv
// Directed bench for spmv_row_mac: hand-computed Q16.16 row sums, latency,
// saturation, hold/backpressure, drop detection and mid-row reset.
module tb_spmv_row_mac;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] vec_row, val_row;
   logic         in_valid, in_ready;
   logic [31:0]  no_of_multiples;
   logic [31:0]  result;
   logic         result_valid, result_ready, overflow, drop_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spmv_row_mac dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .vec_row         (vec_row),
      .val_row         (val_row),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .no_of_multiples (no_of_multiples),
      .result          (result),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .overflow        (overflow),
      .drop_err        (drop_err)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   // Drives one beat for one cycle; returns just after the accepting edge.
   task automatic send_beat(input logic [31:0] v, input logic [31:0] a, input logic [31:0] n);
      vec_row         = {8{v}};
      val_row         = {8{a}};
      no_of_multiples = n;
      in_valid        = 1'b1;
      @(posedge clk); #1;
      in_valid        = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [31:0] exp_res, input logic exp_ovf);
      int lat;
      lat = 0;
      while (!result_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, 4);
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_ovf"}, overflow, exp_ovf);
   endtask

   task automatic handshake(input string tag);
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      chk({tag, "_rv_clr"}, result_valid, 1'b0);
      chk({tag, "_rdy"}, in_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      vec_row         = '0;
      val_row         = '0;
      in_valid        = 1'b0;
      no_of_multiples = 32'd1;
      result_ready    = 1'b0;
      #12;
      chk("rst_res", result, 32'h0);
      chk("rst_rv", result_valid, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_drop", drop_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_rdy", in_ready, 1'b1);

      // 8 x (1.0 * 2.0) = 16.0
      send_beat(32'h0001_0000, 32'h0002_0000, 32'd1);
      chk("one_rdy_lo", in_ready, 1'b0);
      wait_result("one", 32'h0010_0000, 1'b0);
      handshake("one");

      // Three beats of 8 x 0.5; count changes on later beats must be ignored.
      send_beat(32'h0001_0000, 32'h0000_8000, 32'd3);
      send_beat(32'h0001_0000, 32'h0000_8000, 32'd1);
      chk("three_rdy_mid", in_ready, 1'b1);
      send_beat(32'h0001_0000, 32'h0000_8000, 32'd1);
      chk("three_rdy_lo", in_ready, 1'b0);
      wait_result("three", 32'h000C_0000, 1'b0);
      chk("three_rdy_hold", in_ready, 1'b0);
      handshake("three");

      // Positive saturation.
      send_beat(32'h7FFF_0000, 32'h0002_0000, 32'd1);
      wait_result("satp", 32'h7FFF_FFFF, 1'b1);
      handshake("satp");

      // Negative saturation: 8 x (-32768 * 2).
      send_beat(32'h8000_0000, 32'h0002_0000, 32'd1);
      wait_result("satn", 32'h8000_0000, 1'b1);
      handshake("satn");

      // 8 x (-1.0 * 1.0) = -8.0
      send_beat(32'hFFFF_0000, 32'h0001_0000, 32'd1);
      wait_result("neg", 32'hFFF8_0000, 1'b0);
      handshake("neg");

      // Floor shift: raw 1 * raw -1 -> -1 LSB per lane.
      send_beat(32'h0000_0001, 32'hFFFF_FFFF, 32'd1);
      wait_result("floor", 32'hFFFF_FFF8, 1'b0);
      handshake("floor");

      // Count 0 acts as 1; then hold with result_ready low and a dropped beat.
      send_beat(32'h0001_0000, 32'h0002_0000, 32'd0);
      wait_result("zero", 32'h0010_0000, 1'b0);
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("hold_res", result, 32'h0010_0000);
      chk("hold_rv", result_valid, 1'b1);
      chk("hold_rdy", in_ready, 1'b0);
      chk("hold_drop0", drop_err, 1'b0);
      send_beat(32'h0005_0000, 32'h0005_0000, 32'd1);
      chk("hold_drop1", drop_err, 1'b1);
      chk("hold_res2", result, 32'h0010_0000);
      chk("hold_ovf", overflow, 1'b0);
      handshake("zero");
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("drop_noresult", result_valid, 1'b0);

      // Reset after 2 of 4 beats discards the row.
      send_beat(32'h0003_0000, 32'h0003_0000, 32'd4);
      send_beat(32'h0003_0000, 32'h0003_0000, 32'd4);
      rst_n = 1'b0;
      #3;
      chk("mid_rst_rv", result_valid, 1'b0);
      chk("mid_rst_drop", drop_err, 1'b0);
      chk("mid_rst_res", result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_rdy", in_ready, 1'b1);
      repeat (8) begin
         @(posedge clk); #1;
      end
      chk("mid_rst_norow", result_valid, 1'b0);
      send_beat(32'h0001_0000, 32'h0001_0000, 32'd1);
      wait_result("after_rst", 32'h0008_0000, 1'b0);
      handshake("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
